// File: rtl/faultdetector_mac_accum_if.sv
// Operand, multiplier and result signals of the MAC accumulator stage.
// slave is the accumulator's view; master is the view of the surrounding datapath.
interface faultdetector_mac_accum_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [13:0]      s_a;
  logic [14:0]      s_b;
  logic             s_last;
  logic             mul_ce;
  logic [13:0]      mul_din0;
  logic [14:0]      mul_din1;
  logic [28:0]      mul_dout;
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_sum;
  logic [CNT_W-1:0] m_count;
  logic             m_ovf;

  modport slave (
    input  s_valid, s_a, s_b, s_last, mul_dout, m_ready,
    output s_ready, mul_ce, mul_din0, mul_din1, m_valid, m_sum, m_count, m_ovf
  );

  modport master (
    output s_valid, s_a, s_b, s_last, mul_dout, m_ready,
    input  s_ready, mul_ce, mul_din0, mul_din1, m_valid, m_sum, m_count, m_ovf
  );
endinterface

// File: rtl/faultdetector_mac_accum.sv
// Streaming multiply-accumulate around an external pipelined 14x15 multiplier.
// Tags ride alongside the multiplier pipeline; one saturated sum is emitted per group.
module faultdetector_mac_accum #(
  parameter int MUL_LAT = 3,
  parameter int ACC_W   = 40,
  parameter int CNT_W   = 16
) (
  input logic                      clk,
  input logic                      reset,
  faultdetector_mac_accum_if.slave bus
);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {saturated, value}; the product is zero-extended before the add.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [28:0]      prod);
    logic [ACC_W:0] wide;
    wide = {1'b0, acc} + {{(ACC_W-28){1'b0}}, prod};
    if (wide[ACC_W]) begin
      return {1'b1, ACC_MAX};
    end else begin
      return wide;
    end
  endfunction

  // Returns {reached_max, value}; sticks at the maximum once there.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (cnt == CNT_MAX) begin
      return {1'b1, CNT_MAX};
    end else begin
      nxt = cnt + CNT_ONE;
      return {(nxt == CNT_MAX), nxt};
    end
  endfunction

  logic               stall_s;
  logic               ce_s;
  logic               accept_s;
  logic               out_vld_s;
  logic               out_last_s;
  logic               load_s;
  logic               sum_sat_s;
  logic               cnt_hit_s;
  logic [ACC_W-1:0]   nxt_sum_s;
  logic [CNT_W-1:0]   nxt_cnt_s;
  logic               nxt_ovf_s;

  logic [MUL_LAT-1:0] tag_vld_r;
  logic [MUL_LAT-1:0] tag_last_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_r;
  logic               m_valid_r;
  logic [ACC_W-1:0]   m_sum_r;
  logic [CNT_W-1:0]   m_count_r;
  logic               m_ovf_r;

  // A held result freezes the whole pipeline, multiplier included.
  assign stall_s    = m_valid_r && !bus.m_ready;
  assign ce_s       = reset || !stall_s;
  assign accept_s   = bus.s_valid && ce_s;
  assign out_vld_s  = tag_vld_r[MUL_LAT-1];
  assign out_last_s = tag_last_r[MUL_LAT-1];
  assign load_s     = ce_s && out_vld_s && out_last_s;

  assign bus.s_ready  = ce_s;
  assign bus.mul_ce   = ce_s;
  assign bus.mul_din0 = bus.s_a;
  assign bus.mul_din1 = bus.s_b;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_sum    = m_sum_r;
  assign bus.m_count  = m_count_r;
  assign bus.m_ovf    = m_ovf_r;

  // Next accumulator, count and sticky overflow for the product under the out-tag.
  always_comb begin
    sum_sat_s = 1'b0;
    nxt_sum_s = '0;
    cnt_hit_s = 1'b0;
    nxt_cnt_s = '0;
    {sum_sat_s, nxt_sum_s} = sat_add(acc_r, bus.mul_dout);
    {cnt_hit_s, nxt_cnt_s} = sat_inc(cnt_r);
    nxt_ovf_s = ovf_r | sum_sat_s | cnt_hit_s;
  end

  // Tag shift register, kept in lockstep with the multiplier's ce-enabled stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_r  <= '0;
      tag_last_r <= '0;
    end else if (ce_s) begin
      tag_vld_r[0]  <= accept_s;
      tag_last_r[0] <= bus.s_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_r[i]  <= tag_vld_r[i-1];
        tag_last_r[i] <= tag_last_r[i-1];
      end
    end else begin
      tag_vld_r  <= tag_vld_r;
      tag_last_r <= tag_last_r;
    end
  end

  // Running group state; cleared after the closing term so back-to-back groups never merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
      cnt_r <= '0;
      ovf_r <= 1'b0;
    end else if (ce_s && out_vld_s) begin
      if (out_last_s) begin
        acc_r <= '0;
        cnt_r <= '0;
        ovf_r <= 1'b0;
      end else begin
        acc_r <= nxt_sum_s;
        cnt_r <= nxt_cnt_s;
        ovf_r <= nxt_ovf_s;
      end
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
      ovf_r <= ovf_r;
    end
  end

  // Result register: a new group result takes priority over a completing handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_sum_r   <= '0;
      m_count_r <= '0;
      m_ovf_r   <= 1'b0;
    end else if (load_s) begin
      m_valid_r <= 1'b1;
      m_sum_r   <= nxt_sum_s;
      m_count_r <= nxt_cnt_s;
      m_ovf_r   <= nxt_ovf_s;
    end else if (ce_s && bus.m_ready) begin
      m_valid_r <= 1'b0;
      m_sum_r   <= m_sum_r;
      m_count_r <= m_count_r;
      m_ovf_r   <= m_ovf_r;
    end else begin
      m_valid_r <= m_valid_r;
      m_sum_r   <= m_sum_r;
      m_count_r <= m_count_r;
      m_ovf_r   <= m_ovf_r;
    end
  end
endmodule

// File: tb/tb_faultdetector_mac_accum.sv
// Directed and randomized checks of faultdetector_mac_accum against a group-level
// reference model; includes a behavioural model of the 3-stage multiplier.
module tb_faultdetector_mac_accum;
  localparam longint SUM_MAX40 = (64'sd1 <<< 40) - 64'sd1;
  localparam longint CNT_MAX   = 65535;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n_acc  = 0;

  typedef struct {
    longint sum;
    longint cnt;
    longint ovf;
  } res_t;
  res_t   exp_q[$];
  longint run_sum = 0;
  longint run_cnt = 0;

  faultdetector_mac_accum_if #(.ACC_W(40), .CNT_W(16)) bus ();
  faultdetector_mac_accum_if #(.ACC_W(30), .CNT_W(16)) b30 ();

  faultdetector_mac_accum #(.MUL_LAT(3), .ACC_W(40), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  faultdetector_mac_accum #(.MUL_LAT(3), .ACC_W(30), .CNT_W(16)) dut30 (
    .clk(clk), .reset(reset), .bus(b30));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined multiplier models: three ce-enabled stages, no reset.
  logic [28:0] mp0, mp1, mp2, mq0, mq1, mq2;
  always @(posedge clk) begin
    if (bus.mul_ce) begin
      mp0 <= bus.mul_din0 * bus.mul_din1;
      mp1 <= mp0;
      mp2 <= mp1;
    end
    if (b30.mul_ce) begin
      mq0 <= b30.mul_din0 * b30.mul_din1;
      mq1 <= mq0;
      mq2 <= mq1;
    end
  end
  assign bus.mul_dout = mp2;
  assign b30.mul_dout = mq2;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: sum every accepted product per group, saturate once at the end.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      run_sum = 0;
      run_cnt = 0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        chk("result_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          res_t r;
          r = exp_q.pop_front();
          chk("model_sum", longint'(bus.m_sum), r.sum);
          chk("model_count", longint'(bus.m_count), r.cnt);
          chk("model_ovf", longint'(bus.m_ovf), r.ovf);
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        res_t r;
        n_acc++;
        run_sum += longint'(bus.s_a) * longint'(bus.s_b);
        run_cnt++;
        if (bus.s_last) begin
          r.sum = (run_sum > SUM_MAX40) ? SUM_MAX40 : run_sum;
          r.cnt = (run_cnt > CNT_MAX) ? CNT_MAX : run_cnt;
          r.ovf = (run_sum > SUM_MAX40 || run_cnt >= CNT_MAX) ? 1 : 0;
          exp_q.push_back(r);
          run_sum = 0;
          run_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int a, input int b, input int l);
    bus.s_valid = (v != 0);
    bus.s_a     = 14'(a);
    bus.s_b     = 15'(b);
    bus.s_last  = (l != 0);
    #1;
  endtask

  task automatic drive30(input int v, input int a, input int b, input int l);
    b30.s_valid = (v != 0);
    b30.s_a     = 14'(a);
    b30.s_b     = 15'(b);
    b30.s_last  = (l != 0);
    #1;
  endtask

  task automatic wait_mv(input string tag);
    int n;
    n = 0;
    while (!bus.m_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, longint'(bus.m_valid), 1);
  endtask

  task automatic drain();
    int n;
    bus.m_ready = 1'b1;
    drive(0, 0, 0, 0);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_empty", longint'(exp_q.size()), 0);
    chk("drain_group_closed", run_cnt, 0);
  endtask

  task automatic chk30(input string tag, input longint s, input longint c, input longint o);
    chk({tag, "_valid"}, longint'(b30.m_valid), 1);
    chk({tag, "_sum"}, longint'(b30.m_sum), s);
    chk({tag, "_count"}, longint'(b30.m_count), c);
    chk({tag, "_ovf"}, longint'(b30.m_ovf), o);
  endtask

  initial begin
    longint snap_sum;
    int     snap_acc;
    int     base;

    reset = 1'b1;
    bus.m_ready = 1'b1;
    b30.m_ready = 1'b1;
    drive(0, 0, 0, 0);
    drive30(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_s_ready", longint'(bus.s_ready), 1);
    chk("rst_mul_ce", longint'(bus.mul_ce), 1);
    chk("rst_m_valid", longint'(bus.m_valid), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_valid", longint'(bus.m_valid), 0);
    chk("post_rst_sum", longint'(bus.m_sum), 0);
    chk("post_rst_count", longint'(bus.m_count), 0);
    chk("post_rst_ovf", longint'(bus.m_ovf), 0);

    // Three-term group and its latency
    drive(1, 3, 5, 0);
    tick();
    drive(1, 100, 200, 0);
    chk("din0_pass", longint'(bus.mul_din0), 100);
    chk("din1_pass", longint'(bus.mul_din1), 200);
    tick();
    drive(1, 16383, 32767, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    tick();
    chk("t1_not_early", longint'(bus.m_valid), 0);
    tick();
    chk("t1_valid", longint'(bus.m_valid), 1);
    chk("t1_sum", longint'(bus.m_sum), 536841776);
    chk("t1_count", longint'(bus.m_count), 3);
    chk("t1_ovf", longint'(bus.m_ovf), 0);
    tick();

    // Single-term group followed by a two-term group with no bubble
    drive(1, 7, 9, 1);
    tick();
    drive(1, 2, 2, 0);
    tick();
    drive(1, 2, 2, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("t2a_valid", longint'(bus.m_valid), 1);
    chk("t2a_sum", longint'(bus.m_sum), 63);
    chk("t2a_count", longint'(bus.m_count), 1);
    tick();
    chk("t2_gap", longint'(bus.m_valid), 0);
    tick();
    chk("t2b_valid", longint'(bus.m_valid), 1);
    chk("t2b_sum", longint'(bus.m_sum), 8);
    chk("t2b_count", longint'(bus.m_count), 2);
    tick();

    // Back-pressure: result held, pipeline frozen, input refused
    bus.m_ready = 1'b0;
    drive(1, 1, 1, 0);
    tick();
    drive(1, 2, 3, 0);
    tick();
    drive(1, 10, 10, 0);
    tick();
    drive(1, 1000, 1000, 1);
    tick();
    drive(1, 1, 1, 0);
    tick();
    tick();
    tick();
    chk("t3_valid", longint'(bus.m_valid), 1);
    chk("t3_s_ready", longint'(bus.s_ready), 0);
    chk("t3_mul_ce", longint'(bus.mul_ce), 0);
    chk("t3_sum", longint'(bus.m_sum), 1000107);
    chk("t3_count", longint'(bus.m_count), 4);
    snap_sum = longint'(bus.m_sum);
    snap_acc = n_acc;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_sum", longint'(bus.m_sum), snap_sum);
      chk("t3_hold_ready", longint'(bus.s_ready), 0);
    end
    chk("t3_no_accept", longint'(n_acc), longint'(snap_acc));
    bus.m_ready = 1'b1;
    drive(1, 1, 1, 1);
    tick();
    drive(0, 0, 0, 0);
    wait_mv("t3b_valid");
    chk("t3b_sum", longint'(bus.m_sum), 4);
    chk("t3b_count", longint'(bus.m_count), 4);
    tick();

    // Narrow accumulator: just below, above, then recovery
    drive30(1, 16383, 32767, 0);
    tick();
    drive30(1, 16383, 32767, 1);
    tick();
    drive30(0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk30("t4a", 1073643522, 2, 0);
    drive30(1, 16383, 32767, 0);
    tick();
    drive30(1, 16383, 32767, 0);
    tick();
    drive30(1, 16383, 32767, 1);
    tick();
    drive30(0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk30("t4b", 1073741823, 3, 1);
    drive30(1, 1, 1, 1);
    tick();
    drive30(0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk30("t4c", 1, 1, 0);
    tick();

    // Random bubbles and back-pressure, checked by the model
    base = n_acc;
    for (int i = 0; i < 6000 && n_acc < base + 1000; i++) begin
      bus.m_ready = ($urandom_range(0, 1) != 0);
      drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 16383)),
            int'($urandom_range(0, 32767)), int'($urandom_range(0, 3) == 0));
      tick();
    end
    chk("t5_enough_pairs", longint'(n_acc - base >= 1000), 1);
    bus.m_ready = 1'b1;
    drive(1, 3, 3, 1);
    tick();
    drain();
    tick();

    // Reset with two products in flight and a nonzero accumulator
    drive(1, 5, 5, 0);
    tick();
    drive(1, 6, 6, 0);
    tick();
    drive(1, 7, 7, 0);
    tick();
    drive(1, 8, 8, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_ce", longint'(bus.mul_ce), 1);
    chk("t6_rst_ready", longint'(bus.s_ready), 1);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", longint'(bus.m_valid), 0);
    chk("t6_sum", longint'(bus.m_sum), 0);
    chk("t6_count", longint'(bus.m_count), 0);
    chk("t6_ovf", longint'(bus.m_ovf), 0);
    drive(1, 4, 4, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    tick();
    tick();
    chk("t6b_valid", longint'(bus.m_valid), 1);
    chk("t6b_sum", longint'(bus.m_sum), 16);
    chk("t6b_count", longint'(bus.m_count), 1);
    chk("t6b_ovf", longint'(bus.m_ovf), 0);
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
